// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one shifter between r0/r1 (valid/ready cmds: op,data,amt_l,amt_r), one- or two-pass sequencing, rsp_* result tagged by id, sh_* registered drive to the external shifter
module shift_arbiter #(
  parameter int W = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [1:0]    r0_op,
  input  logic [W-1:0]  r0_data,
  input  logic [SW-1:0] r0_amt_l,
  input  logic [SW-1:0] r0_amt_r,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [1:0]    r1_op,
  input  logic [W-1:0]  r1_data,
  input  logic [SW-1:0] r1_amt_l,
  input  logic [SW-1:0] r1_amt_r,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_data,
  output logic [W-1:0]  sh_in,
  output logic          sh_len,
  output logic          sh_ren,
  output logic [SW-1:0] sh_svl,
  output logic [SW-1:0] sh_svr,
  input  logic [W-1:0]  sh_out
);
  typedef enum logic [1:0] {IDLE, P1, P2, RESP} state_t;
  state_t state, nxt;
  logic prio, id, take, rsp_hs;
  logic [1:0] op, req_op;
  logic [W-1:0] data, acc, req_data, n_in;
  logic [SW-1:0] amt_l, amt_r, req_amt_l, req_amt_r, n_svl, n_svr;
  logic n_len, n_ren;
  assign r0_ready = !rst && state == IDLE && r0_valid && (!r1_valid || !prio);
  assign r1_ready = !rst && state == IDLE && r1_valid && (!r0_valid || prio);
  assign take = r0_ready || r1_ready;
  assign rsp_hs = rsp_valid && rsp_ready;
  assign req_op = r1_ready ? r1_op : r0_op;
  assign req_data = r1_ready ? r1_data : r0_data;
  assign req_amt_l = r1_ready ? r1_amt_l : r0_amt_l;
  assign req_amt_r = r1_ready ? r1_amt_r : r0_amt_r;
  // sh_* are loaded with the values for the state being entered, so the
  // shifter sees them for the whole cycle of P1/P2.
  always_comb begin
    nxt = state == IDLE ? (take ? P1 : IDLE) :
          state == P1   ? (op[1] ? P2 : RESP) :
          state == P2   ? RESP : (rsp_hs ? IDLE : RESP);
    n_in = nxt == P1 ? req_data : nxt == P2 ? (op == 2'b10 ? sh_out : data) : '0;
    n_len = nxt == P1 && req_op != 2'b01;
    n_ren = (nxt == P1 && req_op == 2'b01) || nxt == P2;
    n_svl = n_len ? req_amt_l : '0;
    n_svr = nxt == P1 ? (req_op == 2'b01 ? req_amt_r : '0) :
            nxt == P2 ? (op == 2'b10 ? amt_r : SW'(0) - amt_l) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      id <= 1'b0;
      op <= '0;
      data <= '0;
      amt_l <= '0;
      amt_r <= '0;
      acc <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      sh_in <= '0;
      sh_len <= 1'b0;
      sh_ren <= 1'b0;
      sh_svl <= '0;
      sh_svr <= '0;
    end else begin
      state <= nxt;
      sh_in <= n_in;
      sh_len <= n_len;
      sh_ren <= n_ren;
      sh_svl <= n_svl;
      sh_svr <= n_svr;
      if (take) begin
        id <= r1_ready;
        op <= req_op;
        data <= req_data;
        amt_l <= req_amt_l;
        amt_r <= req_amt_r;
      end
      if (state == P1) acc <= sh_out;
      if (state == P2) acc <= op == 2'b10 ? sh_out : acc | sh_out;
      if (state == RESP && !rsp_valid) begin
        rsp_valid <= 1'b1;
        rsp_data <= acc;
        rsp_id <= id;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        prio <= ~id;
      end
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed plus random check of shift_arbiter against an op-level model with a behavioural shifter attached
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0_valid = 1'b0, r1_valid = 1'b0, r0_ready, r1_ready;
  logic [1:0] r0_op = '0, r1_op = '0;
  logic [31:0] r0_data = '0, r1_data = '0;
  logic [4:0] r0_amt_l = '0, r0_amt_r = '0, r1_amt_l = '0, r1_amt_r = '0;
  logic rsp_valid, rsp_id;
  logic rsp_ready = 1'b1;
  logic [31:0] rsp_data, sh_in, sh_out;
  logic sh_len, sh_ren;
  logic [4:0] sh_svl, sh_svr;
  int pass_n = 0, tot_n = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign sh_out = sh_len ? sh_in << sh_svl : sh_ren ? sh_in >> sh_svr : sh_in;
  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_data(r0_data),
    .r0_amt_l(r0_amt_l), .r0_amt_r(r0_amt_r),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_data(r1_data),
    .r1_amt_l(r1_amt_l), .r1_amt_r(r1_amt_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sh_in(sh_in), .sh_len(sh_len), .sh_ren(sh_ren), .sh_svl(sh_svl), .sh_svr(sh_svr),
    .sh_out(sh_out)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tot_n++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    else pass_n++;
  endtask
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                        input logic [4:0] l, input logic [4:0] r);
    logic [31:0] t;
    logic [63:0] x;
    t = d << l;
    x = {d, d} << l;
    return o == 2'd0 ? t : o == 2'd1 ? d >> r : o == 2'd2 ? t >> r : x[63:32];
  endfunction
  logic [32:0] q[$];
  logic [32:0] e;
  bit busy, eprio, pv, g;
  logic pid;
  logic [31:0] pdata;
  int acc_cyc, exp_lat;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      busy = 1'b0;
      eprio = 1'b0;
      pv = 1'b0;
    end else begin
      chk("hygiene", 64'(sh_len & sh_ren), 64'(0));
      chk("one_ready", 64'(r0_ready & r1_ready), 64'(0));
      if (busy) chk("ready_busy", 64'({r0_ready, r1_ready}), 64'(0));
      if ((r0_valid && r0_ready) || (r1_valid && r1_ready)) begin
        g = r1_valid && r1_ready;
        chk("accept_idle", 64'(busy), 64'(0));
        if (r0_valid && r1_valid) chk("grant", 64'(g), 64'(eprio));
        q.push_back(g ? {1'b1, model(r1_op, r1_data, r1_amt_l, r1_amt_r)}
                      : {1'b0, model(r0_op, r0_data, r0_amt_l, r0_amt_r)});
        busy = 1'b1;
        acc_cyc = cyc + 1;
        exp_lat = (g ? r1_op[1] : r0_op[1]) ? 3 : 2;
      end
      if (rsp_valid && !pv) chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
      if (rsp_valid && pv) chk("hold", 64'({rsp_id, rsp_data}), 64'({pid, pdata}));
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 64'(q.size()), 64'(1));
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e[32]));
          chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
          eprio = ~e[32];
        end
        busy = 1'b0;
      end
      pv = rsp_valid;
      pid = rsp_id;
      pdata = rsp_data;
    end
  end
  task automatic set(input bit i, input logic [1:0] o, input logic [31:0] d,
                     input logic [4:0] l, input logic [4:0] r);
    if (i) begin
      r1_op = o; r1_data = d; r1_amt_l = l; r1_amt_r = r; r1_valid = 1'b1;
    end else begin
      r0_op = o; r0_data = d; r0_amt_l = l; r0_amt_r = r; r0_valid = 1'b1;
    end
  endtask
  task automatic take(input bit i);
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (i ? r1_ready : r0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    if (i) r1_valid = 1'b0;
    else r0_valid = 1'b0;
  endtask
  task automatic send(input bit i, input logic [1:0] o, input logic [31:0] d,
                      input logic [4:0] l, input logic [4:0] r);
    set(i, o, d, l, r);
    take(i);
  endtask
  task automatic expect_rsp(input bit i, input logic [31:0] d);
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        chk("dir_id", 64'(rsp_id), 64'(i));
        chk("dir_data", 64'(rsp_data), 64'(d));
        break;
      end
    end
    chk("rsp_seen", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, "_sh_in"}, 64'(sh_in), 64'(0));
    chk({tag, "_sh_ctl"}, 64'({sh_len, sh_ren, sh_svl, sh_svr}), 64'(0));
    chk({tag, "_ready"}, 64'({r0_ready, r1_ready}), 64'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int len_n, ren_n, seen;
    logic [31:0] hd, got;
    logic hid, a0, a1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 2'b00, 32'h1, 5'd31, 5'd0);
    expect_rsp(0, 32'h8000_0000);
    send(1, 2'b01, 32'h8000_0000, 5'd0, 5'd31);
    expect_rsp(1, 32'h1);
    send(0, 2'b10, 32'h1234_5678, 5'd8, 5'd24);
    len_n = 0; ren_n = 0; seen = 0; got = '0;
    repeat (4) begin
      @(negedge clk);
      len_n += int'(sh_len);
      ren_n += int'(sh_ren);
      if (rsp_valid) begin
        seen++;
        got = rsp_data;
      end
    end
    @(posedge clk);
    #1;
    chk("ext_len_cycles", 64'(len_n), 64'(1));
    chk("ext_ren_cycles", 64'(ren_n), 64'(1));
    chk("ext_rsp_seen", 64'(seen), 64'(1));
    chk("ext_data", 64'(got), 64'(32'h34));
    send(1, 2'b11, 32'h8000_0001, 5'd4, 5'd0);
    expect_rsp(1, 32'h18);
    send(1, 2'b11, 32'h8000_0001, 5'd0, 5'd0);
    expect_rsp(1, 32'h8000_0001);
    do_reset();
    set(0, 2'b00, 32'h1, 5'd1, 5'd0);
    set(1, 2'b01, 32'h80, 5'd0, 5'd3);
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (r0_ready || r1_ready) begin
          seen = 1;
          hid = r1_ready;
          break;
        end
      end
      chk("alt_accept", 64'(seen), 64'(1));
      chk("alt_grant", 64'(hid), 64'(k % 2));
      @(posedge clk);
      #1;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    expect_rsp(1, 32'h10);
    rsp_ready = 1'b0;
    set(0, 2'b00, 32'hF0, 5'd4, 5'd0);
    set(1, 2'b01, 32'hFF, 5'd0, 5'd4);
    take(0);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    hd = rsp_data;
    hid = rsp_id;
    chk("bp_seen", 64'(seen), 64'(1));
    chk("bp_first_data", 64'(hd), 64'(32'hF00));
    chk("bp_first_id", 64'(hid), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_data", 64'(rsp_data), 64'(hd));
      chk("bp_id", 64'(rsp_id), 64'(hid));
      chk("bp_ready", 64'({r0_ready, r1_ready}), 64'(0));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    take(1);
    expect_rsp(1, 32'hF);
    send(0, 2'b00, 32'h5, 5'd1, 5'd0);
    expect_rsp(0, 32'hA);
    send(0, 2'b10, 32'h1234_5678, 5'd8, 5'd24);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 64'(seen), 64'(0));
    @(posedge clk);
    #1;
    set(0, 2'b00, 32'h3, 5'd2, 5'd0);
    set(1, 2'b01, 32'h100, 5'd0, 5'd4);
    take(0);
    expect_rsp(0, 32'hC);
    take(1);
    expect_rsp(1, 32'h10);
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      a0 = r0_valid && r0_ready;
      a1 = r1_valid && r1_ready;
      @(posedge clk);
      #1;
      if (!r0_valid || a0) begin
        r0_valid = 1'($urandom_range(0, 1));
        r0_op = 2'($urandom_range(0, 3));
        r0_data = $urandom;
        r0_amt_l = 5'($urandom_range(0, 31));
        r0_amt_r = 5'($urandom_range(0, 31));
      end
      if (!r1_valid || a1) begin
        r1_valid = 1'($urandom_range(0, 1));
        r1_op = 2'($urandom_range(0, 3));
        r1_data = $urandom;
        r1_amt_l = 5'($urandom_range(0, 31));
        r1_amt_r = 5'($urandom_range(0, 31));
      end
      rsp_ready = $urandom_range(0, 3) != 0;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
